// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, fflags bit positions, operand classes, FSQRT states.
// Latency: none (declarations only).
// Backpressure: n/a.
package fpu_pkg;

    // RISC-V rounding-mode encodings
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // fflags bit indices within {NV,DZ,OF,UF,NX}
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_SNAN,
        CLS_QNAN
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_ROUND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fsqrt_round.sv
// Rounds the truncated root (mantissa + guard + sticky) and renormalises on mantissa carry-out.
// Latency: combinational.
// Backpressure: none; the parent holds inputs stable while the result is captured.
module fsqrt_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W-1:0] root_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic [2:0]       rm_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [MAN_W-1:0] man_o,
    output logic [EXP_W-1:0] exp_o,
    output logic             nx_o
);

    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    logic           inc;
    logic [MAN_W:0] sum;

    // Root is always positive, so RTZ and RDN truncate; a carry-out means the root reached 2.0
    always_comb begin
        inc = 1'b0;
        case (rm_i)
            RM_RNE:  inc = guard_i & (sticky_i | root_i[0]);
            RM_RUP:  inc = guard_i | sticky_i;
            RM_RMM:  inc = guard_i;
            default: inc = 1'b0;
        endcase
        sum   = {1'b0, root_i} + {{MAN_W{1'b0}}, inc};
        man_o = sum[MAN_W-1:0];
        exp_o = sum[MAN_W] ? (exp_i + EXP_ONE) : exp_i;
        nx_o  = guard_i | sticky_i;
    end

endmodule

// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 square root, one root bit per cycle (restoring recurrence); FSQRT_SUBNORM_EN enables subnormal inputs (else DAZ).
// Latency: specials 1 cycle after accept, finite positive operands MAN_W+5 cycles after accept.
// Backpressure: in_ready_o only in IDLE; result held in DONE until out_ready_i; flush_i aborts from any state.
module fsqrt_iter
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [EXP_W+MAN_W:0]     rs1_i,
    input  logic [2:0]               rm_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [4:0]               fflags_o
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int ITERS = MAN_W + 2;          // hidden + MAN_W + guard
    localparam int RW    = MAN_W + 5;          // partial-remainder working width
    localparam int DW    = 2 * ITERS;          // radicand, two bits consumed per step
    localparam int CW    = $clog2(ITERS + 1);
    localparam int SEW   = EXP_W + 2;          // signed unbiased exponent width
    localparam logic [EXP_W-1:0] BIAS = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_e             state_q;
    logic [EXP_W-1:0]   op_exp_q;
    logic [MAN_W-1:0]   op_man_q;
    logic [2:0]         rm_q;
    logic [DW-1:0]      rad_q;
    logic [RW-3:0]      rem_q;
    logic [ITERS-1:0]   root_q;
    logic [CW-1:0]      cnt_q;
    logic [EXP_W-1:0]   rexp_q;
    logic [W-1:0]       result_q;
    logic [4:0]         fflags_q;

    // ---------------- operand classification at accept ----------------
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    cls_e             in_cls;
    logic             spec_d;
    logic [W-1:0]     spec_res_d;
    logic [4:0]       spec_flags_d;

    assign in_sign = rs1_i[W-1];
    assign in_exp  = rs1_i[W-2:MAN_W];
    assign in_man  = rs1_i[MAN_W-1:0];

    // Classify the raw operand from its exponent and mantissa fields
    always_comb begin
        in_cls = CLS_NORM;
        if (in_exp == {EXP_W{1'b1}}) begin
            if (in_man == '0)          in_cls = CLS_INF;
            else if (in_man[MAN_W-1])  in_cls = CLS_QNAN;
            else                       in_cls = CLS_SNAN;
        end else if (in_exp == '0) begin
            in_cls = (in_man == '0) ? CLS_ZERO : CLS_SUB;
        end
    end

    // Decide whether the result is known without iterating, and what it is
    always_comb begin
        spec_d       = 1'b1;
        spec_res_d   = QNAN;
        spec_flags_d = '0;
        case (in_cls)
            CLS_SNAN: spec_flags_d[FF_NV] = 1'b1;
            CLS_QNAN: spec_res_d = QNAN;
            CLS_INF: begin
                if (in_sign) spec_flags_d[FF_NV] = 1'b1;
                else         spec_res_d = rs1_i;
            end
            CLS_ZERO: spec_res_d = rs1_i;
            CLS_SUB: begin
`ifdef FSQRT_SUBNORM_EN
                if (in_sign) spec_flags_d[FF_NV] = 1'b1;
                else         spec_d = 1'b0;
`else
                // denormals-are-zero: signed zero in, same signed zero out
                spec_res_d = {in_sign, {(W-1){1'b0}}};
`endif
            end
            default: begin
                if (in_sign) spec_flags_d[FF_NV] = 1'b1;
                else         spec_d = 1'b0;
            end
        endcase
    end

    // ---------------- PREP: normalise, halve exponent, build radicand ----------------
    logic [MAN_W:0]          sig_d;
    logic [SEW-1:0]          e_d;
    logic signed [SEW-1:0]   r_d;
    logic [SEW-1:0]          rexp_full_d;
    logic [DW-1:0]           rad_d;

`ifdef FSQRT_SUBNORM_EN
    localparam int LZW = $clog2(MAN_W + 2);
    logic [LZW-1:0] lzc_d;

    // Leading zeros of {0, mantissa}: the highest set bit overrides lower ones
    always_comb begin
        lzc_d = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (op_man_q[i]) lzc_d = LZW'(MAN_W - i);
        end
    end
`endif

    // Significand in [1,2), doubled for odd exponents so the exponent halves exactly
    always_comb begin
`ifdef FSQRT_SUBNORM_EN
        if (op_exp_q == '0) begin
            sig_d = {1'b0, op_man_q} << lzc_d;
            e_d   = SEW'(1) - SEW'(BIAS) - SEW'(lzc_d);
        end else begin
            sig_d = {1'b1, op_man_q};
            e_d   = SEW'(op_exp_q) - SEW'(BIAS);
        end
`else
        sig_d = {1'b1, op_man_q};
        e_d   = SEW'(op_exp_q) - SEW'(BIAS);
`endif
        rad_d       = e_d[0] ? {sig_d, {(MAN_W+3){1'b0}}}
                             : {1'b0, sig_d, {(MAN_W+2){1'b0}}};
        r_d         = $signed(e_d) >>> 1;
        rexp_full_d = r_d + SEW'(BIAS);
    end

    // ---------------- ITER: one restoring step ----------------
    logic [RW-1:0] part_d;
    logic [RW-1:0] sub_d;
    logic [RW-1:0] trial_d;
    logic          ge_d;

    // Bring down the next radicand pair and try subtracting {root,01}
    always_comb begin
        part_d  = {rem_q, rad_q[DW-1:DW-2]};
        sub_d   = {1'b0, root_q, 2'b01};
        ge_d    = (part_d >= sub_d);
        trial_d = part_d - sub_d;
    end

    // ---------------- ROUND ----------------
    logic [MAN_W-1:0] rnd_man;
    logic [EXP_W-1:0] rnd_exp;
    logic             rnd_nx;
    logic [4:0]       rnd_flags_d;

    fsqrt_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .root_i   (root_q[ITERS-2:1]),
        .guard_i  (root_q[0]),
        .sticky_i (|rem_q),
        .rm_i     (rm_q),
        .exp_i    (rexp_q),
        .man_o    (rnd_man),
        .exp_o    (rnd_exp),
        .nx_o     (rnd_nx)
    );

    // Only inexact can be raised by a finite positive root
    always_comb begin
        rnd_flags_d        = '0;
        rnd_flags_d[FF_NX] = rnd_nx;
    end

    // Remainder stays below 2*root, so these high bits are always zero; hidden root bit is always 1
    logic unused_bits;
    assign unused_bits = ^{trial_d[RW-1:RW-2], rexp_full_d[SEW-1:EXP_W], root_q[ITERS-1]};

    // ---------------- control FSM ----------------
    // Sequence accept -> PREP -> ITERS steps -> ROUND -> DONE; flush overrides everything but reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            op_exp_q <= '0;
            op_man_q <= '0;
            rm_q     <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            rexp_q   <= '0;
            result_q <= '0;
            fflags_q <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        op_exp_q <= in_exp;
                        op_man_q <= in_man;
                        rm_q     <= rm_i;
                        if (spec_d) begin
                            result_q <= spec_res_d;
                            fflags_q <= spec_flags_d;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    rad_q   <= rad_d;
                    rem_q   <= '0;
                    root_q  <= '0;
                    cnt_q   <= '0;
                    rexp_q  <= rexp_full_d[EXP_W-1:0];
                    state_q <= ST_ITER;
                end
                ST_ITER: begin
                    rad_q  <= {rad_q[DW-3:0], 2'b00};
                    rem_q  <= ge_d ? trial_d[RW-3:0] : part_d[RW-3:0];
                    root_q <= {root_q[ITERS-2:0], ge_d};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITERS - 1)) state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    result_q <= {1'b0, rnd_exp, rnd_man};
                    fflags_q <= rnd_flags_d;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign result_o    = result_q;
    assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// Self-checking bench for fsqrt_iter (single precision); honours FSQRT_SUBNORM_EN for subnormal expectations.
// Latency: checks 1-cycle specials and 28-cycle normal operations.
// Backpressure: exercises out_ready_i hold, flush mid-ITER, flush in DONE/IDLE and async reset.
module tb_fsqrt_iter;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] rs1_i;
    logic [2:0]  rm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    fsqrt_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .rs1_i       (rs1_i),
        .rm_i        (rm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .fflags_o    (fflags_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NV   = 5'b10000;
    localparam logic [4:0] F_NX   = 5'b00001;
    localparam int         LAT_N  = 28;
    localparam int         LAT_S  = 1;

    typedef struct {
        logic [31:0] op;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_chk  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    int          lat;
    int          bad;
    int          x0;
    int          seen;
    exp_t        e;
    logic [31:0] snap;

    // Count real result transfers (a flush in the same cycle cancels consumption)
    always @(negedge clk_i) begin
        if (out_valid_o && out_ready_i && !flush_i) n_xfer++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] op, input logic [2:0] rm,
                                input logic [31:0] res, input logic [4:0] flg, input int l);
        vec_t v;
        v.op  = op;
        v.rm  = rm;
        v.res = res;
        v.flg = flg;
        v.lat = l;
        return v;
    endfunction

    // Present one operand for one cycle; returns one cycle after the accept edge
    task automatic issue(input logic [31:0] op, input logic [2:0] rm);
        in_valid_i = 1'b1;
        rs1_i      = op;
        rm_i       = rm;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    // Wait (bounded) for the result, compare against the scoreboard head, then consume it
    task automatic collect(input string nm);
        int   l;
        exp_t ex;
        l = 1;
        while (!out_valid_o && l < 200) begin
            @(posedge clk_i); #1;
            l++;
        end
        ex = sb.pop_front();
        check({nm, " latency"}, 64'(l), 64'(ex.lat));
        check({nm, " result"}, 64'(result_o), 64'(ex.res));
        check({nm, " fflags"}, 64'(fflags_o), 64'(ex.flg));
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check({nm, " back to idle"}, 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        reset_ni    = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        rs1_i       = '0;
        rm_i        = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset in_ready", 64'(in_ready_o), 64'd1);
        check("reset out_valid", 64'(out_valid_o), 64'd0);
        check("reset result", 64'(result_o), 64'd0);
        check("reset fflags", 64'(fflags_o), 64'd0);
        reset_ni = 1'b1;
        @(posedge clk_i); #1;

        vecs.push_back(mk(32'h40800000, 3'b000, 32'h40000000, F_NONE, LAT_N)); // 4.0
        vecs.push_back(mk(32'h40000000, 3'b000, 32'h3FB504F3, F_NX,   LAT_N)); // 2.0 RNE
        vecs.push_back(mk(32'h40000000, 3'b001, 32'h3FB504F3, F_NX,   LAT_N)); // 2.0 RTZ
        vecs.push_back(mk(32'h40000000, 3'b011, 32'h3FB504F4, F_NX,   LAT_N)); // 2.0 RUP
        vecs.push_back(mk(32'h40000000, 3'b010, 32'h3FB504F3, F_NX,   LAT_N)); // 2.0 RDN
        vecs.push_back(mk(32'h40000000, 3'b100, 32'h3FB504F3, F_NX,   LAT_N)); // 2.0 RMM
        vecs.push_back(mk(32'h3F800000, 3'b000, 32'h3F800000, F_NONE, LAT_N)); // 1.0
        vecs.push_back(mk(32'h41100000, 3'b000, 32'h40400000, F_NONE, LAT_N)); // 9.0
        vecs.push_back(mk(32'h40400000, 3'b000, 32'h3FDDB3D7, F_NX,   LAT_N)); // 3.0
        vecs.push_back(mk(32'h7F7FFFFF, 3'b000, 32'h5F7FFFFF, F_NX,   LAT_N)); // max normal
        vecs.push_back(mk(32'h7F7FFFFF, 3'b011, 32'h5F800000, F_NX,   LAT_N)); // carry-out renormalise
        vecs.push_back(mk(32'hBF800000, 3'b000, 32'h7FC00000, F_NV,   LAT_S)); // -1.0
        vecs.push_back(mk(32'h7F800001, 3'b000, 32'h7FC00000, F_NV,   LAT_S)); // sNaN
        vecs.push_back(mk(32'h7FC00000, 3'b000, 32'h7FC00000, F_NONE, LAT_S)); // qNaN
        vecs.push_back(mk(32'hFF800000, 3'b000, 32'h7FC00000, F_NV,   LAT_S)); // -inf
        vecs.push_back(mk(32'h80000000, 3'b000, 32'h80000000, F_NONE, LAT_S)); // -0
        vecs.push_back(mk(32'h00000000, 3'b000, 32'h00000000, F_NONE, LAT_S)); // +0
        vecs.push_back(mk(32'h7F800000, 3'b000, 32'h7F800000, F_NONE, LAT_S)); // +inf
`ifdef FSQRT_SUBNORM_EN
        vecs.push_back(mk(32'h00400000, 3'b000, 32'h1FB504F3, F_NX,   LAT_N)); // 2^-127
        vecs.push_back(mk(32'h80400000, 3'b000, 32'h7FC00000, F_NV,   LAT_S)); // -2^-127
`else
        vecs.push_back(mk(32'h00400000, 3'b000, 32'h00000000, F_NONE, LAT_S));
        vecs.push_back(mk(32'h80400000, 3'b000, 32'h80000000, F_NONE, LAT_S));
`endif

        foreach (vecs[i]) begin
            sb.push_back('{res: vecs[i].res, flg: vecs[i].flg, lat: vecs[i].lat});
            issue(vecs[i].op, vecs[i].rm);
            collect($sformatf("vec%0d", i));
        end

        // Back-pressure: hold the result for 10 cycles, then exactly one transfer
        sb.push_back('{res: 32'h40000000, flg: F_NONE, lat: LAT_N});
        issue(32'h40800000, 3'b000);
        lat = 1;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        e = sb.pop_front();
        check("bp latency", 64'(lat), 64'(e.lat));
        check("bp result", 64'(result_o), 64'(e.res));
        snap = result_o;
        bad  = 0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (result_o !== snap || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) bad++;
        end
        check("bp hold stable", 64'(bad), 64'd0);
        x0 = n_xfer;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        repeat (3) begin @(posedge clk_i); #1; end
        check("bp transfer count", 64'(n_xfer - x0), 64'd1);
        check("bp drained", 64'(out_valid_o), 64'd0);

        // Flush in the middle of the iteration
        issue(32'h40000000, 3'b000);
        repeat (10) begin @(posedge clk_i); #1; end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush idle", 64'(in_ready_o), 64'd1);
        check("flush no valid", 64'(out_valid_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (out_valid_o) seen++;
        end
        check("flush silent", 64'(seen), 64'd0);
        sb.push_back('{res: 32'h40000000, flg: F_NONE, lat: LAT_N});
        issue(32'h40800000, 3'b000);
        collect("after flush");

        // Flush and out_ready together in DONE: flush wins, nothing consumed
        issue(32'h7F800000, 3'b000);
        x0 = n_xfer;
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        check("done flush valid", 64'(out_valid_o), 64'd0);
        check("done flush no xfer", 64'(n_xfer - x0), 64'd0);

        // Flush with in_valid in IDLE: no accept
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        rs1_i      = 32'h40800000;
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("idle flush no accept", 64'(in_ready_o), 64'd1);

        // Asynchronous reset mid-operation
        issue(32'h40800000, 3'b000);
        repeat (5) begin @(posedge clk_i); #1; end
        #2;
        reset_ni = 1'b0;
        #1;
        check("arst in_ready", 64'(in_ready_o), 64'd1);
        check("arst out_valid", 64'(out_valid_o), 64'd0);
        check("arst result", 64'(result_o), 64'd0);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        @(posedge clk_i); #1;
        sb.push_back('{res: 32'h3F800000, flg: F_NONE, lat: LAT_N});
        issue(32'h3F800000, 3'b000);
        collect("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no summary by 1000000 ns, required completion");
        $fatal(1);
    end

endmodule
